address_bus_reg: RTL

ADDRESS_BUS_REG -- requirements
Module: address_bus_reg

---
 rtl/cpu6502_pkg.sv | 40 ++++
 rtl/vector_sequencer.sv | 75 +++++++
 rtl/address_bus_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu6502_pkg.sv
// Shared encodings for the 6502-style address bus register and vector sequencer.
package cpu6502_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } addr_t;

  localparam logic [2:0] AB_SRC_PC      = 3'd0;
  localparam logic [2:0] AB_SRC_AD      = 3'd1;
  localparam logic [2:0] AB_SRC_ZP      = 3'd2;
  localparam logic [2:0] AB_SRC_STACK   = 3'd3;
  localparam logic [2:0] AB_SRC_INDEXED = 3'd4;

  localparam logic [1:0] VEC_NMI   = 2'd0;
  localparam logic [1:0] VEC_RESET = 2'd1;
  localparam logic [1:0] VEC_IRQ   = 2'd2;

  localparam logic [BYTE_W-1:0] VEC_LO_NMI   = 8'hFA;
  localparam logic [BYTE_W-1:0] VEC_LO_RESET = 8'hFC;
  localparam logic [BYTE_W-1:0] VEC_LO_IRQ   = 8'hFE;
  localparam logic [BYTE_W-1:0] VEC_HI       = 8'hFF;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH_LO = 2'd1;
  localparam logic [1:0] ST_FETCH_HI = 2'd2;
  localparam logic [1:0] ST_LOAD     = 2'd3;

  // Reserved vector kind behaves as IRQ.
  function automatic logic [BYTE_W-1:0] vec_lo_byte(input logic [1:0] kind);
    case (kind)
      VEC_NMI:   vec_lo_byte = VEC_LO_NMI;
      VEC_RESET: vec_lo_byte = VEC_LO_RESET;
      default:   vec_lo_byte = VEC_LO_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/vector_sequencer.sv
// Interrupt/reset vector fetch FSM: fetches the two vector bytes on clk_ph2 edges
// and pulses vec_load for one ph2 period.
module vector_sequencer
  import cpu6502_pkg::*;
(
  input  logic              sys_clock,
  input  logic              rst,
  input  logic              clk_ph2,
  input  logic              vec_req,
  input  logic [1:0]        vec_type,
  input  logic [BYTE_W-1:0] DBin,
  output logic [BYTE_W-1:0] vec_PCL,
  output logic [BYTE_W-1:0] vec_PCH,
  output logic              vec_load,
  output logic              vec_busy,
  output logic [BYTE_W-1:0] vec_lo_c,
  output logic              vec_drive_c
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [BYTE_W-1:0] pcl_d, pch_d;
  logic              load_d, busy_d;

  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      type_q   <= VEC_RESET;
      vec_PCL  <= '0;
      vec_PCH  <= '0;
      vec_load <= 1'b0;
      vec_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      vec_PCL  <= pcl_d;
      vec_PCH  <= pch_d;
      vec_load <= load_d;
      vec_busy <= busy_d;
    end
  end

  // State only moves on ph2; requests are ignored until back in IDLE.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pcl_d   = vec_PCL;
    pch_d   = vec_PCH;
    if (clk_ph2) begin
      case (state_q)
        ST_IDLE: begin
          if (vec_req) begin
            state_d = ST_FETCH_LO;
            type_d  = vec_type;
          end
        end
        ST_FETCH_LO: begin
          pcl_d   = DBin;
          state_d = ST_FETCH_HI;
        end
        ST_FETCH_HI: begin
          pch_d   = DBin;
          state_d = ST_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    load_d = (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE);
  end

  assign vec_drive_c = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);
  assign vec_lo_c    = vec_lo_byte(type_q) + BYTE_W'(state_q == ST_FETCH_HI);

endmodule

// File: rtl/address_bus_reg.sv
// External address bus register with source mux and vector fetch sequencer.
// Optional AB_PAGE_CROSS_EN: indexed mode carries into ABH and reports page_cross.
module address_bus_reg
  import cpu6502_pkg::*;
(
  input  logic              sys_clock,
  input  logic              rst,
  input  logic              clk_ph1,
  input  logic              clk_ph2,
  input  logic [BYTE_W-1:0] PCLin,
  input  logic [BYTE_W-1:0] PCHin,
  input  logic [BYTE_W-1:0] ADLin,
  input  logic [BYTE_W-1:0] ADHin,
  input  logic [BYTE_W-1:0] IDXin,
  input  logic [BYTE_W-1:0] SPin,
  input  logic [BYTE_W-1:0] DBin,
  input  logic [2:0]        AB_src,
  input  logic              vec_req,
  input  logic [1:0]        vec_type,
  output logic [BYTE_W-1:0] ABL,
  output logic [BYTE_W-1:0] ABH,
  output logic [BYTE_W-1:0] vec_PCL,
  output logic [BYTE_W-1:0] vec_PCH,
  output logic              vec_load,
  output logic              vec_busy,
  output logic              page_cross
);

  addr_t             addr_q, addr_d, src_addr_c;
  logic              src_hold_c;
  logic [BYTE_W-1:0] vec_lo_c;
  logic              vec_drive_c;
`ifdef AB_PAGE_CROSS_EN
  logic              carry_c, page_q, page_d;
`endif

  vector_sequencer u_vector_sequencer (
    .sys_clock   (sys_clock),
    .rst         (rst),
    .clk_ph2     (clk_ph2),
    .vec_req     (vec_req),
    .vec_type    (vec_type),
    .DBin        (DBin),
    .vec_PCL     (vec_PCL),
    .vec_PCH     (vec_PCH),
    .vec_load    (vec_load),
    .vec_busy    (vec_busy),
    .vec_lo_c    (vec_lo_c),
    .vec_drive_c (vec_drive_c)
  );

  // Source decode; codes 5-7 hold the current address.
  always_comb begin
    src_addr_c = addr_q;
    src_hold_c = 1'b0;
`ifdef AB_PAGE_CROSS_EN
    carry_c    = 1'b0;
`endif
    case (AB_src)
      AB_SRC_PC:    src_addr_c = {PCHin, PCLin};
      AB_SRC_AD:    src_addr_c = {ADHin, ADLin};
      AB_SRC_ZP:    src_addr_c = {8'h00, ADLin};
      AB_SRC_STACK: src_addr_c = {8'h01, SPin};
      AB_SRC_INDEXED: begin
`ifdef AB_PAGE_CROSS_EN
        {carry_c, src_addr_c.lo} = {1'b0, ADLin} + {1'b0, IDXin};
        src_addr_c.hi = ADHin + BYTE_W'(carry_c);
`else
        src_addr_c.lo = ADLin + IDXin;
        src_addr_c.hi = ADHin;
`endif
      end
      default: src_hold_c = 1'b1;
    endcase
  end

  // ph1 update: vector address while busy (held in LOAD), else selected source.
  always_comb begin
    addr_d = addr_q;
`ifdef AB_PAGE_CROSS_EN
    page_d = page_q;
`endif
    if (clk_ph1) begin
      if (vec_busy) begin
        if (vec_drive_c) begin
          addr_d = {VEC_HI, vec_lo_c};
`ifdef AB_PAGE_CROSS_EN
          page_d = 1'b0;
`endif
        end
      end else if (!src_hold_c) begin
        addr_d = src_addr_c;
`ifdef AB_PAGE_CROSS_EN
        page_d = carry_c;
`endif
      end
    end
  end

  always_ff @(posedge sys_clock or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
`ifdef AB_PAGE_CROSS_EN
      page_q <= 1'b0;
`endif
    end else begin
      addr_q <= addr_d;
`ifdef AB_PAGE_CROSS_EN
      page_q <= page_d;
`endif
    end
  end

  assign ABL = addr_q.lo;
  assign ABH = addr_q.hi;
`ifdef AB_PAGE_CROSS_EN
  assign page_cross = page_q;
`else
  assign page_cross = 1'b0;
`endif

endmodule
